// File: rtl/bus_interconnect_if.sv
// ---------------------------------------------------------------------------
// bus_interconnect_if
//   Signal bundle between the CPU data port, the interconnect and the
//   SLAVE_CNT peripherals.
//   Master side : mReq, mWE, mAddr, mWData, mWMask -> ; <- mReady, mErr, mRData
//   Slave side  : sSel, sWE, sAddr, sWData, sWMask -> ; <- sRData, sReady
//   modport slave  : the interconnect's view (answers the CPU, drives slaves)
//   modport master : the environment's view (CPU plus peripherals)
// ---------------------------------------------------------------------------
interface bus_interconnect_if #(
    parameter int SLAVE_CNT = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic                        mReq;
    logic                        mWE;
    logic [ADDR_W-1:0]           mAddr;
    logic [DATA_W-1:0]           mWData;
    logic [DATA_W/8-1:0]         mWMask;
    logic                        mReady;
    logic                        mErr;
    logic [DATA_W-1:0]           mRData;
    logic [SLAVE_CNT-1:0]        sSel;
    logic                        sWE;
    logic [ADDR_W-1:0]           sAddr;
    logic [DATA_W-1:0]           sWData;
    logic [DATA_W/8-1:0]         sWMask;
    logic [SLAVE_CNT*DATA_W-1:0] sRData;
    logic [SLAVE_CNT-1:0]        sReady;

    modport slave (
        input  mReq, mWE, mAddr, mWData, mWMask, sRData, sReady,
        output mReady, mErr, mRData, sSel, sWE, sAddr, sWData, sWMask
    );

    modport master (
        output mReq, mWE, mAddr, mWData, mWMask, sRData, sReady,
        input  mReady, mErr, mRData, sSel, sWE, sAddr, sWData, sWMask
    );
endinterface

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//   Single-master, one-transaction-at-a-time interconnect. Decodes the master
//   address against per-slave windows, runs a ready/wait-state handshake with
//   the selected slave, returns registered read data and flags bus errors for
//   unmapped addresses and slave timeouts.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : bus_interconnect_if.slave (master request/response + slave side)
// ---------------------------------------------------------------------------
module bus_interconnect #(
    parameter int                          SLAVE_CNT  = 4,
    parameter int                          ADDR_W     = 32,
    parameter int                          DATA_W     = 32,
    parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_BASE = {32'h30000, 32'h20000, 32'h10000, 32'h0},
    parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_MASK = {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFF0, 32'hFFFF0000},
    parameter int                          TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               reset,
    bus_interconnect_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;
    // At least one bit so a disabled timeout still yields a legal vector.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t                state_q, state_d;
    logic [SLAVE_CNT-1:0]  sel_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [MASK_W-1:0]     wmask_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    // Address decode; walking downwards lets the lowest index win on overlap.
    logic [SLAVE_CNT-1:0]  hit_sel;
    logic [ADDR_W-1:0]     hit_off;
    logic                  hit;

    always_comb begin
        hit_sel = '0;
        hit_off = '0;
        for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
            if ((bus.mAddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit_off    = bus.mAddr & ~SLAVE_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hit = |hit_sel;

    // Only the latched slave's ready/data are looked at.
    logic              s_rdy;
    logic [DATA_W-1:0] s_rdata;

    always_comb begin
        s_rdy   = |(bus.sReady & sel_q);
        s_rdata = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            if (sel_q[i]) s_rdata = s_rdata | bus.sRData[i*DATA_W +: DATA_W];
        end
    end

    logic tmo;
    assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.mReq) state_d = hit ? ACCESS : ERR;
            ACCESS:  if (s_rdy || tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs, decoded from state and latches only
    always_comb begin
        bus.mReady = (state_q == RESP) || (state_q == ERR);
        bus.mErr   = (state_q == ERR) || ((state_q == RESP) && err_q);
        bus.mRData = rdata_q;
        bus.sSel   = (state_q == ACCESS) ? sel_q : '0;
        bus.sWE    = (state_q == ACCESS) && we_q;
        bus.sAddr  = addr_q;
        bus.sWData = wdata_q;
        bus.sWMask = wmask_q;
    end

    // Request latches, wait counter and response data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.mReq) begin
                    sel_q   <= hit_sel;
                    we_q    <= bus.mWE;
                    addr_q  <= hit ? hit_off : bus.mAddr;
                    wdata_q <= bus.mWData;
                    wmask_q <= bus.mWMask;
                    rdata_q <= '0;   // ERR answers with zero data
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                ACCESS: begin
                    // A ready in the last allowed cycle still wins over the timeout.
                    if (s_rdy) begin
                        rdata_q <= s_rdata;
                        err_q   <= 1'b0;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt_q   <= cnt_q + 1'b1;   // stops at TIMEOUT-1, never wraps
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// ---------------------------------------------------------------------------
// tb_bus_interconnect
//   Directed scenarios followed by randomized transactions, each checked
//   cycle by cycle against a window-table reference model.
// ---------------------------------------------------------------------------
module tb_bus_interconnect;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    localparam logic [31:0] BASE [N] = '{32'h0, 32'h10000, 32'h20000, 32'h30000};
    localparam logic [31:0] MASK [N] = '{32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFF00, 32'hFFFFFF00};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bus_interconnect_if #(.SLAVE_CNT(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_interconnect #(.SLAVE_CNT(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int last_resp  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference decode: first window (lowest index) containing the address.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] rnd_rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge of the idle
    // cycle following the response, so callers can chain requests with no gap.
    // waits = ACCESS cycles with sReady low before the slave answers.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] mk, input int waits, input logic [31:0] rd,
                       input bit busy_req);
        int          idx;
        int          acc;
        bit          e_err;
        logic [31:0] off;
        logic [3:0]  onehot;
        idx = decode(addr);
        bus.mReq   = 1'b1;
        bus.mWE    = we;
        bus.mAddr  = addr;
        bus.mWData = wd;
        bus.mWMask = mk;
        bus.sReady = '0;
        bus.sRData = rnd_rdata();
        @(negedge clk);
        // While busy, either drop mReq or keep presenting junk that must be ignored.
        if (busy_req) begin
            bus.mWE    = ~we;
            bus.mAddr  = $urandom;
            bus.mWData = $urandom;
            bus.mWMask = 4'($urandom);
        end else begin
            bus.mReq = 1'b0;
        end
        if (idx < 0) begin
            chk("unmapped_mReady", bus.mReady, 1);
            chk("unmapped_mErr",   bus.mErr,   1);
            chk("unmapped_mRData", bus.mRData, 0);
            chk("unmapped_sSel",   bus.sSel,   0);
        end else begin
            onehot = 4'b0001 << idx;
            off    = addr & ~MASK[idx];
            acc    = (waits < TMO) ? waits + 1 : TMO;
            for (int c = 0; c < acc; c++) begin
                chk("acc_sSel",   bus.sSel,   onehot);
                chk("acc_sAddr",  bus.sAddr,  off);
                chk("acc_sWE",    bus.sWE,    we);
                chk("acc_sWData", bus.sWData, wd);
                chk("acc_sWMask", bus.sWMask, mk);
                chk("acc_mReady", bus.mReady, 0);
                // Unselected slaves may babble; only the selected one counts.
                bus.sReady = 4'($urandom) & ~onehot;
                if (c == waits) begin
                    bus.sReady = bus.sReady | onehot;
                    bus.sRData[idx*DW +: DW] = rd;
                end
                @(negedge clk);
                bus.sReady = '0;
                bus.sRData = rnd_rdata();
            end
            e_err = (waits >= TMO);
            chk("resp_mReady", bus.mReady, 1);
            chk("resp_mErr",   bus.mErr,   e_err);
            chk("resp_mRData", bus.mRData, e_err ? 32'h0 : rd);
            chk("resp_sSel",   bus.sSel,   0);
        end
        last_resp = cyc;
        @(negedge clk);
        chk("idle_mReady", bus.mReady, 0);
        chk("idle_sSel",   bus.sSel,   0);
        bus.mReq = 1'b0;
    endtask

    initial begin
        int          prev;
        int          kind;
        int          w;
        logic [31:0] a;
        bus.mReq   = 1'b0;
        bus.mWE    = 1'b0;
        bus.mAddr  = '0;
        bus.mWData = '0;
        bus.mWMask = '0;
        bus.sReady = '0;
        bus.sRData = '0;

        // Reset state
        #12;
        chk("rst_mReady", bus.mReady, 0);
        chk("rst_mErr",   bus.mErr,   0);
        chk("rst_mRData", bus.mRData, 0);
        chk("rst_sSel",   bus.sSel,   0);
        chk("rst_sWE",    bus.sWE,    0);
        chk("rst_sAddr",  bus.sAddr,  0);
        chk("rst_sWData", bus.sWData, 0);
        chk("rst_sWMask", bus.sWMask, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Zero-wait read, waited write, unmapped, timeout
        txn(1'b0, 32'h0000_0010, 32'h0,  4'h0, 0,   32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h0001_0004, 32'h55, 4'h1, 2,   32'h1234_5678, 1'b0);
        txn(1'b0, 32'h0009_0000, 32'h0,  4'h0, 0,   32'h0,        1'b0);
        txn(1'b0, 32'h0002_0000, 32'h0,  4'h0, 100, 32'hFFFF_FFFF, 1'b0);
        // Ready on the very last allowed cycle still succeeds; zero-mask write is normal.
        txn(1'b1, 32'h0003_00FC, 32'hA5, 4'h0, TMO - 1, 32'hCAFE_F00D, 1'b0);

        // Reset during a slave3 wait
        bus.mReq  = 1'b1;
        bus.mWE   = 1'b0;
        bus.mAddr = 32'h0003_0044;
        @(negedge clk);
        bus.mReq = 1'b0;
        chk("midrst_sSel_before", bus.sSel, 4'b1000);
        @(negedge clk);
        chk("midrst_sSel_wait", bus.sSel, 4'b1000);
        #2 reset = 1'b0;
        #1;
        chk("midrst_sSel",   bus.sSel,   0);
        chk("midrst_mReady", bus.mReady, 0);
        chk("midrst_sAddr",  bus.sAddr,  0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0);

        // Back-to-back with mReq held high: one response every 3 cycles
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            txn(1'b0, (i % 2 == 0) ? 32'h0000_0020 : 32'h0001_0008, 32'h0, 4'h0, 0,
                $urandom, 1'b1);
            if (prev >= 0) chk("b2b_spacing", last_resp - prev, 3);
            prev = last_resp;
        end

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            if (kind < N) a = BASE[kind] | ($urandom & ~MASK[kind]);
            else          a = $urandom;
            w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            txn(1'($urandom), a, $urandom, 4'($urandom), w, $urandom, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
